// File: rtl/fir_pkg.sv
// Shared constants for the 16-tap FIR: tap count, coefficient set and
// accumulator sizing. Imported by fir_filter and fir_mac_tap.
package fir_pkg;

  localparam int unsigned NumTaps = 16;

  // Headroom above the product width; the coefficient sum (156) needs < 2^4 growth
  // relative to a single full-scale product's magnitude budget.
  localparam int unsigned AccGuardBits = 4;

  // Symmetric low-pass kernel, sum 156.
  localparam int Coeffs [NumTaps] = '{1, 2, 4, 7, 11, 15, 18, 20, 20, 18, 15, 11, 7, 4, 2, 1};

  // Accumulator width for a given coefficient and sample width.
  function automatic int unsigned acc_width(int unsigned coef_w, int unsigned sample_w);
    return coef_w + sample_w + AccGuardBits;
  endfunction

endpackage

// File: rtl/fir_mac_tap.sv
// One FIR tap: full-width signed product of a delay-line sample and its coefficient.
module fir_mac_tap #(
  parameter int unsigned N1 = 8,
  parameter int unsigned N2 = 16
) (
  input  logic signed [N1-1:0]    coef,
  input  logic signed [N2-1:0]    sample,
  output logic signed [N1+N2-1:0] product
);

  // Both operands sign-extended to the product width so no bits are lost.
  always_comb begin
    product = (N1 + N2)'(coef) * (N1 + N2)'(sample);
  end

endmodule

// File: rtl/fir_filter.sv
// 16-tap direct-form FIR with registered output.
// Optional build macro FIR_OUT_SCALE_EN: output is the accumulator rounded and
// scaled by 2^-(N1-1) (coefficients read as Q1.(N1-1)); otherwise full precision.
// Requires N3 >= N1 + N2 + 4.
module fir_filter
  import fir_pkg::*;
#(
  parameter int unsigned N1 = 8,
  parameter int unsigned N2 = 16,
  parameter int unsigned N3 = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic signed [N2-1:0] input_data,
  output logic signed [N3-1:0] filtered_data,
  output logic signed [N2-1:0] sample_T
);

  localparam int unsigned ProdW = N1 + N2;
  localparam int unsigned AccW  = acc_width(N1, N2);

  logic signed [N2-1:0]    x_q  [NumTaps];
  logic signed [ProdW-1:0] prod [NumTaps];
  logic signed [AccW-1:0]  acc;
  logic signed [N3-1:0]    filt_d;
  logic signed [N3-1:0]    filt_q;

  // One multiplier per tap against the current (pre-shift) delay line.
  for (genvar i = 0; i < NumTaps; i++) begin : g_tap
    localparam logic signed [N1-1:0] Coef = N1'(Coeffs[i]);

    fir_mac_tap #(
      .N1(N1),
      .N2(N2)
    ) u_tap (
      .coef   (Coef),
      .sample (x_q[i]),
      .product(prod[i])
    );
  end

  // Sum all sign-extended products into the guarded accumulator.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NumTaps; i++) begin
      acc = acc + AccW'(prod[i]);
    end
  end

`ifdef FIR_OUT_SCALE_EN
  localparam int RoundBias = 1 << (N1 - 2);

  logic signed [AccW-1:0] acc_rnd;
  logic signed [AccW-1:0] acc_scaled;

  // Round half up, then arithmetic shift out the coefficient fraction bits.
  always_comb begin
    acc_rnd    = acc + AccW'(RoundBias);
    acc_scaled = acc_rnd >>> (N1 - 1);
    filt_d     = N3'(acc_scaled);
  end
`else
  // Full-precision result, sign-extended to the output width.
  always_comb begin
    filt_d = N3'(acc);
  end
`endif

  // Delay line and output register; reset wins over enable and wipes history.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NumTaps; i++) begin
        x_q[i] <= '0;
      end
      filt_q <= '0;
    end else if (ENABLE) begin
      x_q[0] <= input_data;
      for (int i = 1; i < NumTaps; i++) begin
        x_q[i] <= x_q[i-1];
      end
      filt_q <= filt_d;
    end
  end

  assign filtered_data = filt_q;
  assign sample_T      = x_q[0];

endmodule

// File: tb/tb_fir_filter.sv
// Directed self-checking bench for fir_filter (default and FIR_OUT_SCALE_EN builds).
module tb_fir_filter;

  logic               CLK;
  logic               RST;
  logic               ENABLE;
  logic signed [15:0] input_data;
  logic signed [31:0] filtered_data;
  logic signed [15:0] sample_T;

  int n_tests;
  int n_fail;

  // Hand-written impulse response for a unit impulse, one entry per enabled edge.
  int imp_resp [18] = '{0, 1, 2, 4, 7, 11, 15, 18, 20, 20, 18, 15, 11, 7, 4, 2, 1, 0};
  int coef_tab [16] = '{1, 2, 4, 7, 11, 15, 18, 20, 20, 18, 15, 11, 7, 4, 2, 1};

  fir_filter #(
    .N1(8),
    .N2(16),
    .N3(32)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ENABLE       (ENABLE),
    .input_data   (input_data),
    .filtered_data(filtered_data),
    .sample_T     (sample_T)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  // Expected output for a full-precision accumulator value in the current build.
  function automatic int scale(input int full);
`ifdef FIR_OUT_SCALE_EN
    return (full + 64) >>> 7;
`else
    return full;
`endif
  endfunction

  // Sum of the first n coefficients (step response shape).
  function automatic int psum(input int n);
    int s = 0;
    for (int i = 0; i < n && i < 16; i++) s += coef_tab[i];
    return s;
  endfunction

  // Apply inputs, take one rising edge, settle 1 time unit past it.
  task automatic tick(input logic en, input logic rst, input int data);
    ENABLE     = en;
    RST        = rst;
    input_data = 16'(data);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b1, 555);
    check("reset_filt", filtered_data, 0);
    check("reset_sample", 32'(sample_T), 0);
  endtask

  task automatic run_impulse(input int amp, input string tag);
    int peak;
    do_reset();
    peak = 0;
    for (int k = 0; k < 18; k++) begin
      tick(1'b1, 1'b0, (k == 0) ? amp : 0);
      check({tag, "_filt"}, filtered_data, scale(amp * imp_resp[k]));
      check({tag, "_sample"}, 32'(sample_T), (k == 0) ? amp : 0);
      if ((amp < 0 && filtered_data < peak) || (amp > 0 && filtered_data > peak))
        peak = filtered_data;
    end
    check({tag, "_peak"}, peak, scale(amp * 20));
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    ENABLE     = 1'b0;
    RST        = 1'b0;
    input_data = '0;
    #2;

    // Impulse response, unit amplitude.
    run_impulse(1, "imp1");

    // Full negative scale; peak -655360 is 32'hFFF60000 at full precision.
    run_impulse(-32768, "negfs");
`ifndef FIR_OUT_SCALE_EN
    do_reset();
    for (int k = 0; k < 9; k++) tick(1'b1, 1'b0, (k == 0) ? -32768 : 0);
    check("negfs_bits", filtered_data, 32'hFFF6_0000);
`endif

    // Impulse of 128: in the scaled build this returns the coefficients.
    run_impulse(128, "imp128");

    // Step response: settles at 156*100 from the 17th enabled edge.
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      tick(1'b1, 1'b0, 100);
      check("step", filtered_data, scale(100 * psum(e - 1)));
    end
    check("step_final", filtered_data, scale(15600));

    // Reset mid-stream discards history; step restarts from 0.
    do_reset();
    for (int e = 1; e <= 8; e++) tick(1'b1, 1'b0, 100);
    check("mid_pre", filtered_data, scale(100 * psum(7)));
    tick(1'b1, 1'b1, 100);
    check("mid_rst_filt", filtered_data, 0);
    check("mid_rst_sample", 32'(sample_T), 0);
    for (int e = 1; e <= 4; e++) begin
      tick(1'b1, 1'b0, 100);
      check("mid_restart", filtered_data, scale(100 * psum(e - 1)));
    end

    // Enable gating: freeze 5 cycles with a different input, then resume.
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      tick(1'b1, 1'b0, 100);
      check("gate_pre", filtered_data, scale(100 * psum(e - 1)));
    end
    for (int c = 0; c < 5; c++) begin
      tick(1'b0, 1'b0, 7777);
      check("gate_hold_filt", filtered_data, scale(100 * psum(5)));
      check("gate_hold_sample", 32'(sample_T), 100);
    end
    for (int e = 7; e <= 10; e++) begin
      tick(1'b1, 1'b0, 100);
      check("gate_resume", filtered_data, scale(100 * psum(e - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_filter.md
FIR_FILTER -- requirements
Module: fir_filter

Interface
REQ-001 SHALL have parameter N1, default 8: coefficient word width, signed two's complement.
REQ-002 SHALL have parameter N2, default 16: input sample width, signed two's complement.
REQ-003 SHALL have parameter N3, default 32: output word width, signed; N3 >= N1+N2+4.
REQ-004 SHALL have port CLK, input, 1: the single clock, with all state updating on its rising edge.
REQ-005 SHALL have port RST, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port ENABLE, input, 1: high means capture a sample and advance the filter this cycle.
REQ-007 SHALL have port input_data, input, N2: new signed sample.
REQ-008 SHALL have port filtered_data, output, N3: registered signed filter result.
REQ-009 SHALL have port sample_T, output, N2: most recently captured sample (delay-line tap 0).

Function
REQ-010 SHALL implement a 16-tap direct-form FIR with delay line x[0..15] of N2 bits each.
REQ-011 SHALL use fixed signed coefficients c[0..15] = 1,2,4,7,11,15,18,20,20,18,15,11,7,4,2,1 (sum 156).
REQ-012 SHALL, on a rising edge with ENABLE=1 and RST=0, load x[0]<=input_data and x[i]<=x[i-1] for i=1..15.
REQ-013 SHALL, on the same edge, load filtered_data <= sum over i of c[i]*x[i], using the pre-shift delay-line contents.
REQ-014 SHALL therefore show a sample in filtered_data one enabled edge after the edge that captured it; the latency is 2 enabled edges from input_data being presented.
REQ-015 SHALL form each product at full N1+N2 width, accumulate at N1+N2+4 bits, and sign-extend to N3 with no overflow or truncation.
REQ-016 SHALL, with ENABLE=0, hold the delay line, filtered_data and sample_T unchanged.
REQ-017 SHALL drive sample_T continuously from x[0].
REQ-018 SHALL accept input_data of -2^(N2-1) (full negative scale) and produce exact results.

Reset
REQ-019 SHALL, on a rising edge with RST=1, clear all x[i], filtered_data and sample_T to 0, regardless of ENABLE.
REQ-020 SHALL give RST priority over ENABLE, with a reset mid-stream discarding all history.
REQ-021 SHALL, on the first enabled edge after reset, capture the new sample and compute a filtered_data of 0.

Configuration
REQ-022 SHALL, when macro FIR_OUT_SCALE_EN is defined, set filtered_data = (acc + 2^(N1-2)) >>> (N1-1), i.e. rounded Q1.(N1-1) coefficient scaling, sign-extended to N3.
REQ-023 SHALL, when FIR_OUT_SCALE_EN is undefined, output the full-precision accumulator per REQ-015.

Structure
REQ-024 SHALL place the tap count (16), the coefficient constant array and the accumulator-width constant in shared package fir_pkg.
REQ-025 SHALL have at most one sub-module, fir_mac_tap (one signed multiply of x[i] by c[i]), instantiated 16 times via generate; the accumulation and registers stay in fir_filter.

Verification
REQ-026 SHALL verify impulse response: after reset, apply input 1 then 0 each enabled cycle; filtered_data SHALL follow 0,1,2,4,7,11,15,18,20,20,18,15,11,7,4,2,1,0.
REQ-027 SHALL verify step response: hold input 100 enabled for 20 cycles; filtered_data SHALL reach and hold 15600 from the 17th enabled edge onward.
REQ-028 SHALL verify negative full scale: apply an impulse of -32768; the output peak SHALL be -655360 and the sign extension to 32 bits SHALL be correct.
REQ-029 SHALL verify enable gating: drop ENABLE for 5 cycles mid-stream; filtered_data and sample_T SHALL stay frozen, and the sequence SHALL resume unchanged afterwards.
REQ-030 SHALL verify reset mid-stream: assert RST for 1 cycle during the step test; all outputs SHALL be 0 on the next edge, and the step response SHALL restart from 0.
REQ-031 SHALL verify the macro build: with FIR_OUT_SCALE_EN, an impulse of 128 SHALL yield outputs equal to the coefficient sequence.
